// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES definitions. GF(2^8) helpers, S-box and inverse
//                S-box (computed from the field inverse plus the affine
//                map), round constants, key-size to round-count mapping
//                and the encrypt/decrypt mode type.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef enum logic {
        ENC = 1'b0,
        DEC = 1'b1
    } aes_mode_e;

    // Round constants rcon[1..10], rcon[1] in the MSB byte
    localparam logic [79:0] c_rcon = 80'h01020408102040801b36;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // Field inverse as a^254; zero maps to zero as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] y;
        y = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // idx counts from 1
    function automatic logic [7:0] rcon(input int idx);
        return c_rcon[79-8*(idx-1) -: 8];
    endfunction

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_unit.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_unit
//  Description : One combinational AES round. Forward: SubBytes, ShiftRows,
//                MixColumns (skipped when i_is_last), AddRoundKey. Inverse:
//                InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns
//                (skipped when i_is_last). Byte k of the state is row k%4,
//                column k/4, held at bits [127-8k -: 8].
//  Config      : AES_ITER_DECRYPT_EN builds the inverse path; otherwise
//                i_inverse is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_round_unit
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_rkey,
    input  logic         i_is_last,
    input  logic         i_inverse,
    output logic [127:0] o_state
);

    logic [7:0]   w_in  [16];
    logic [7:0]   w_sr  [16];
    logic [7:0]   w_mc  [16];
    logic [127:0] w_enc;

    // Unpack the state into bytes
    always_comb begin
        for (int k = 0; k < 16; k++) w_in[k] = i_state[127-8*k -: 8];
    end

    // Forward round: row r rotates left by r columns
    always_comb begin
        w_enc = '0;
        for (int k = 0; k < 16; k++)
            w_sr[k] = sbox(w_in[4*(((k/4) + (k%4)) % 4) + (k%4)]);
        for (int c = 0; c < 4; c++) begin
            w_mc[4*c]   = xtime(w_sr[4*c]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ w_sr[4*c+3];
            w_mc[4*c+1] = w_sr[4*c] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2]) ^ w_sr[4*c+2] ^ w_sr[4*c+3];
            w_mc[4*c+2] = w_sr[4*c] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2]) ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
            w_mc[4*c+3] = xtime(w_sr[4*c]) ^ w_sr[4*c] ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
        end
        for (int k = 0; k < 16; k++)
            w_enc[127-8*k -: 8] = (i_is_last ? w_sr[k] : w_mc[k]) ^ i_rkey[127-8*k -: 8];
    end

`ifdef AES_ITER_DECRYPT_EN
    logic [7:0]   w_ark [16];
    logic [127:0] w_dec;

    // Inverse round: row r rotates right by r columns, key added before InvMixColumns
    always_comb begin
        w_dec = '0;
        for (int k = 0; k < 16; k++)
            w_ark[k] = inv_sbox(w_in[4*(((k/4) + 4 - (k%4)) % 4) + (k%4)]) ^ i_rkey[127-8*k -: 8];
        for (int c = 0; c < 4; c++) begin
            w_dec[127-8*(4*c)   -: 8] = i_is_last ? w_ark[4*c] :
                gmul(w_ark[4*c], 8'd14) ^ gmul(w_ark[4*c+1], 8'd11) ^ gmul(w_ark[4*c+2], 8'd13) ^ gmul(w_ark[4*c+3], 8'd9);
            w_dec[127-8*(4*c+1) -: 8] = i_is_last ? w_ark[4*c+1] :
                gmul(w_ark[4*c], 8'd9) ^ gmul(w_ark[4*c+1], 8'd14) ^ gmul(w_ark[4*c+2], 8'd11) ^ gmul(w_ark[4*c+3], 8'd13);
            w_dec[127-8*(4*c+2) -: 8] = i_is_last ? w_ark[4*c+2] :
                gmul(w_ark[4*c], 8'd13) ^ gmul(w_ark[4*c+1], 8'd9) ^ gmul(w_ark[4*c+2], 8'd14) ^ gmul(w_ark[4*c+3], 8'd11);
            w_dec[127-8*(4*c+3) -: 8] = i_is_last ? w_ark[4*c+3] :
                gmul(w_ark[4*c], 8'd11) ^ gmul(w_ark[4*c+1], 8'd13) ^ gmul(w_ark[4*c+2], 8'd9) ^ gmul(w_ark[4*c+3], 8'd14);
        end
    end

    assign o_state = i_inverse ? w_dec : w_enc;
`else
    logic w_unused_inverse;
    assign w_unused_inverse = i_inverse;
    assign o_state          = w_enc;
`endif

endmodule
`default_nettype wire

// File: rtl/keyExpansion.sv
`default_nettype none
// ============================================================================
//  Module      : keyExpansion
//  Description : Combinational AES key schedule. Expands an NK-word cipher
//                key into NR+1 round keys; round key r sits at
//                o_round_keys[128*r +: 128] with its first word in the MSBs.
//  Revision    : 1.0 - initial release
// ============================================================================
module keyExpansion
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
)(
    input  logic [32*NK-1:0]      i_key,
    output logic [128*(NR+1)-1:0] o_round_keys
);

    localparam int NW = 4 * (NR + 1);

    // Word-by-word FIPS-197 expansion, then packing into round keys
    always_comb begin : blk_expand
        logic [31:0] words [NW];
        logic [31:0] tmp;
        tmp          = '0;
        o_round_keys = '0;
        for (int i = 0; i < NW; i++) begin
            if (i < NK) begin
                words[i] = i_key[32*(NK-1-i) +: 32];
            end else begin
                tmp = words[i-1];
                if (i % NK == 0)
                    tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon(i / NK), 24'h000000};
                else if (NK > 6 && i % NK == 4)
                    tmp = sub_word(tmp);
                words[i] = words[i-NK] ^ tmp;
            end
            o_round_keys[128*(i/4) + 32*(3 - i%4) +: 32] = words[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : aes_iter_core
//  Description : Iterative AES-128/192/256 core, one round per clock.
//                Valid/ready on both sides; the result is held until the
//                consumer takes it. A block is accepted only from IDLE, so
//                consecutive blocks are NR+2 cycles apart.
//  Config      : AES_ITER_DECRYPT_EN enables the inverse cipher and honours
//                in_mode; without it every block is encrypted.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [127:0]        in_data,
    input  logic [KEY_BITS-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
);

    localparam int NK  = KEY_BITS / 32;
    localparam int NR  = nr_of(KEY_BITS);
    localparam int RCW = 4;

    localparam logic [RCW-1:0] c_nr   = RCW'(NR);
    localparam logic [1:0]     c_idle = 2'd0;
    localparam logic [1:0]     c_run  = 2'd1;
    localparam logic [1:0]     c_done = 2'd2;

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
    end

    logic [1:0]                r_fsm;
    logic [1:0]                w_fsm_nxt;
    logic [RCW-1:0]            r_rnd;
    logic [127:0]              r_blk;
    logic [KEY_BITS-1:0]       r_key;
    logic [127:0]              r_out_data;
    logic                      r_out_valid;
    logic                      w_accept;
    logic                      w_is_last;
    logic [KEY_BITS-1:0]       w_key_src;
    logic [128*(NR+1)-1:0]     w_rkeys;
    logic [RCW-1:0]            w_rk_step;
    logic [RCW-1:0]            w_rk_idx;
    logic [127:0]              w_rk_sel;
    logic [127:0]              w_round_out;
    aes_mode_e                 w_mode_cur;

    assign w_accept  = in_valid && in_ready;
    assign w_is_last = (r_rnd == c_nr);

    // While idle the schedule runs on the incoming key so the whitening key is ready at accept
    assign w_key_src = (r_fsm == c_idle) ? in_key : r_key;

`ifdef AES_ITER_DECRYPT_EN
    aes_mode_e r_mode;

    assign w_mode_cur = (r_fsm == c_idle) ? aes_mode_e'(in_mode) : r_mode;

    // Mode is captured with the block
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_mode <= ENC;
        else if (w_accept) r_mode <= aes_mode_e'(in_mode);
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = in_mode;
    assign w_mode_cur    = ENC;
`endif

    // Encrypt walks keys upward from rk[0], decrypt walks down from rk[NR]
    assign w_rk_step = (r_fsm == c_idle) ? '0 : r_rnd;
    assign w_rk_idx  = (w_mode_cur == DEC) ? (c_nr - w_rk_step) : w_rk_step;
    assign w_rk_sel  = w_rkeys[128*w_rk_idx +: 128];

    keyExpansion #(
        .NK (NK),
        .NR (NR)
    ) u_key_exp (
        .i_key        (w_key_src),
        .o_round_keys (w_rkeys)
    );

    aes_round_unit u_round (
        .i_state   (r_blk),
        .i_rkey    (w_rk_sel),
        .i_is_last (w_is_last),
        .i_inverse (w_mode_cur == DEC),
        .o_state   (w_round_out)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fsm <= c_idle;
        else     r_fsm <= w_fsm_nxt;
    end

    // FSM next state: DONE always returns to IDLE, never straight to RUN
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            c_idle:  if (w_accept)  w_fsm_nxt = c_run;
            c_run:   if (w_is_last) w_fsm_nxt = c_done;
            c_done:  if (out_ready) w_fsm_nxt = c_idle;
            default: w_fsm_nxt = c_idle;
        endcase
    end

    // FSM outputs; in_ready is held low while reset is asserted
    always_comb begin
        in_ready = (r_fsm == c_idle) && !rst;
        busy     = (r_fsm == c_run) || (r_fsm == c_done);
    end

    // Datapath: whitening at accept, one round per RUN cycle, result capture on the last round
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk       <= '0;
            r_key       <= '0;
            r_rnd       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                c_idle: begin
                    if (w_accept) begin
                        r_blk <= in_data ^ w_rk_sel;
                        r_key <= in_key;
                        r_rnd <= RCW'(1);
                    end
                end
                c_run: begin
                    r_blk <= w_round_out;
                    if (w_is_last) begin
                        r_rnd       <= '0;
                        r_out_data  <= w_round_out;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_rnd <= r_rnd + RCW'(1);
                    end
                end
                c_done: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_aes_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_iter_core
//  Description : Self-checking bench for aes_iter_core. One instance per key
//                size shares clk/rst; expected results go into a scoreboard
//                queue when a block is driven and are popped on out_valid.
//  Config      : AES_ITER_DECRYPT_EN selects decrypt expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_iter_core;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         in_mode   [3];
    logic [127:0] in_data   [3];
    logic [255:0] in_key    [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         busy      [3];

    logic [127:0] exp_q [$];
    int           n_tests = 0;
    int           n_fail  = 0;

    aes_iter_core #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_mode(in_mode[0]),
        .in_data(in_data[0]), .in_key(in_key[0][255:128]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0])
    );

    aes_iter_core #(.KEY_BITS(192)) u_dut192 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_mode(in_mode[1]),
        .in_data(in_data[1]), .in_key(in_key[1][255:64]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1])
    );

    aes_iter_core #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_mode(in_mode[2]),
        .in_data(in_data[2]), .in_key(in_key[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one block on instance d, optionally stall the consumer for hold cycles
    task automatic run_block(input int d, input logic mode, input logic [127:0] data,
                             input logic [255:0] key, input logic [127:0] exp,
                             input int nr, input int hold, input string tag);
        int           edges;
        logic [127:0] held;
        logic [127:0] want;
        @(negedge clk);
        chk({tag, "_ready_idle"}, in_ready[d], 1);
        in_valid[d]  = 1'b1;
        in_mode[d]   = mode;
        in_data[d]   = data;
        in_key[d]    = key;
        out_ready[d] = (hold == 0);
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        chk({tag, "_busy_run"}, {busy[d], in_ready[d]}, 2'b10);
        // Inputs are don't-care once accepted
        in_valid[d] = 1'b0;
        in_mode[d]  = ~mode;
        in_data[d]  = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_key[d]   = {8{$urandom()}};
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!out_valid[d] && edges < 40);
        chk({tag, "_latency"}, 128'(edges), 128'(nr));
        if (exp_q.size() == 0) begin
            chk({tag, "_scoreboard"}, 0, 1);
        end else begin
            want = exp_q.pop_front();
            chk({tag, "_data"}, out_data[d], want);
        end
        if (hold > 0) begin
            held        = out_data[d];
            in_valid[d] = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                chk({tag, "_hold_data"}, out_data[d], held);
                chk({tag, "_hold_flags"}, {out_valid[d], in_ready[d], busy[d]}, 3'b101);
            end
            out_ready[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, "_retire"}, {out_valid[d], in_ready[d], busy[d]}, 3'b010);
        in_valid[d] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_mode[d]   = 1'b0;
            in_data[d]   = '0;
            in_key[d]    = '0;
            out_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            chk($sformatf("reset_state%0d", d),
                {out_data[d], out_valid[d], in_ready[d], busy[d]}, 131'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++)
            chk($sformatf("ready_after_reset%0d", d), in_ready[d], 1);

        run_block(0, 1'b0, PT, K128, CT128, 10, 0, "enc128");
        run_block(1, 1'b0, PT, K192, CT192, 12, 0, "enc192");
        run_block(2, 1'b0, PT, K256, CT256, 14, 0, "enc256");
        run_block(1, 1'b0, PT, K192, CT192, 12, 20, "backpressure192");
        run_block(0, 1'b0, PT, K128, CT128, 10, 0, "back2back128");
`ifdef AES_ITER_DECRYPT_EN
        run_block(2, 1'b1, CT256, K256, PT, 14, 0, "dec256");
        run_block(0, 1'b1, CT128, K128, PT, 10, 3, "dec128");
        run_block(1, 1'b1, CT192, K192, PT, 12, 0, "dec192");
`else
        run_block(0, 1'b1, PT, K128, CT128, 10, 0, "mode_ignored128");
        run_block(2, 1'b1, PT, K256, CT256, 14, 0, "mode_ignored256");
`endif

        // Reset in the middle of a block on the 128-bit instance
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_mode[0]  = 1'b0;
        in_data[0]  = PT;
        in_key[0]   = K128;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrun_reset_out", {out_data[0], out_valid[0]}, 129'h0);
        chk("midrun_reset_flags", {in_ready[0], busy[0]}, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrun_release_ready", in_ready[0], 1);
        begin
            int seen;
            seen = 0;
            repeat (20) begin
                @(posedge clk);
                #1;
                if (out_valid[0] || busy[0]) seen++;
            end
            chk("midrun_no_output", 128'(seen), 0);
        end
        run_block(0, 1'b0, PT, K128, CT128, 10, 0, "post_reset128");

        chk("scoreboard_empty", 128'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
